// File: rtl/avalon_pio_ext_pkg.sv
// Shared constants for the Avalon-MM PIO block: register addresses and
// the encodings accepted by the EDGE_TYPE and IRQ_MODE parameters.
package avalon_pio_pkg;

  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_DIRECTION    = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_OUTSET       = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/avalon_pio_ext_if.sv
// Avalon-MM slave bus bundle for the PIO block: zero-wait-state accesses,
// no waitrequest or readdatavalid.
interface avalon_pio_ext_if #(
  parameter int DATA_WIDTH = 32
);
  logic [2:0]            address;
  logic                  chipselect;
  logic                  write_n;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_pio_ext_sync_edge.sv
// Input synchroniser chain plus one history stage; produces the synchronised
// pin vector and a one-cycle pulse per bit on the selected edge.
module pio_sync_edge
  import avalon_pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] sync_in,
  output logic [DATA_WIDTH-1:0] edge_pulse
);

  logic [DATA_WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] prev_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg[0] <= '0;
    end else begin
      sync_reg[0] <= in_port;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync_reg[gi] <= '0;
        end else begin
          sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  // History resets low, so a pin held high through reset yields one rising pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_reg <= '0;
    end else begin
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign sync_in = sync_reg[SYNC_STAGES-1];

  generate
    if (EDGE_TYPE == EDGE_RISING) begin : g_rise
      assign edge_pulse = sync_in & ~prev_reg;
    end else if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
      assign edge_pulse = ~sync_in & prev_reg;
    end else begin : g_any
      assign edge_pulse = sync_in ^ prev_reg;
    end
  endgenerate

endmodule

// File: rtl/avalon_pio_ext.sv
// Avalon-MM PIO slave: output register with atomic set/clear, per-bit
// direction, synchronised inputs, sticky edge capture and a maskable irq.
module avalon_pio_ext
  import avalon_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    EDGE_TYPE   = EDGE_RISING,
  parameter int                    IRQ_MODE    = IRQ_LEVEL,
  parameter logic [DATA_WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  avalon_pio_ext_if.slave        bus,
  input  logic [DATA_WIDTH-1:0]  in_port,
  output logic [DATA_WIDTH-1:0]  out_port,
  output logic [DATA_WIDTH-1:0]  oe,
  output logic                   irq
);

  logic [DATA_WIDTH-1:0] sync_in;
  logic [DATA_WIDTH-1:0] edge_pulse;

  logic [DATA_WIDTH-1:0] data_out_reg,  data_out_next;
  logic [DATA_WIDTH-1:0] direction_reg, direction_next;
  logic [DATA_WIDTH-1:0] irq_mask_reg,  irq_mask_next;
  logic [DATA_WIDTH-1:0] capture_reg,   capture_next;
  logic                  irq_reg,       irq_next;
  logic                  wr;

  pio_sync_edge #(
    .DATA_WIDTH (DATA_WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port   (in_port),
    .sync_in   (sync_in),
    .edge_pulse(edge_pulse)
  );

  assign wr = bus.chipselect & ~bus.write_n;

  always_comb begin
    data_out_next  = data_out_reg;
    direction_next = direction_reg;
    irq_mask_next  = irq_mask_reg;
    capture_next   = capture_reg;
    if (wr) begin
      case (bus.address)
        ADDR_DATA:         data_out_next  = bus.writedata;
        ADDR_DIRECTION:    direction_next = bus.writedata;
        ADDR_IRQ_MASK:     irq_mask_next  = bus.writedata;
        ADDR_EDGE_CAPTURE: capture_next   = capture_reg & ~bus.writedata;
        ADDR_OUTSET:       data_out_next  = data_out_reg | bus.writedata;
        ADDR_OUTCLEAR:     data_out_next  = data_out_reg & ~bus.writedata;
        default:           ;
      endcase
    end
    // A fresh edge overrides a simultaneous clear so no event is ever lost.
    capture_next = capture_next | edge_pulse;
  end

  generate
    if (IRQ_MODE == IRQ_EDGE) begin : g_irq_edge
      assign irq_next = |(capture_reg & irq_mask_reg);
    end else begin : g_irq_level
      assign irq_next = |(sync_in & irq_mask_reg);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_reg  <= OUT_RESET;
      direction_reg <= '0;
      irq_mask_reg  <= '0;
      capture_reg   <= '0;
      irq_reg       <= 1'b0;
    end else begin
      data_out_reg  <= data_out_next;
      direction_reg <= direction_next;
      irq_mask_reg  <= irq_mask_next;
      capture_reg   <= capture_next;
      irq_reg       <= irq_next;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:         bus.readdata = sync_in;
      ADDR_DIRECTION:    bus.readdata = direction_reg;
      ADDR_IRQ_MASK:     bus.readdata = irq_mask_reg;
      ADDR_EDGE_CAPTURE: bus.readdata = capture_reg;
      default:           bus.readdata = '0;
    endcase
  end

  assign out_port = data_out_reg;
  assign oe       = direction_reg;
  assign irq      = irq_reg;

endmodule
